// File: rtl/msg_block_assembler.sv
// Collects indexed message bytes into one zero-padded 64-byte block and hands it
// to the BLAKE2 compression core over a valid/ready handshake, tracking t and first/last.
module msg_block_assembler #(
    parameter int BLOCK_BYTES = 64,
    parameter int IDX_W       = 6,
    parameter int LL_W        = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     data_v_i,
    input  logic [7:0]               data_i,
    input  logic [IDX_W-1:0]         data_idx_i,
    input  logic                     block_first_i,
    input  logic                     block_last_i,
    input  logic [LL_W-1:0]          ll_i,
    output logic                     ready_v_o,
    output logic                     block_v_o,
    input  logic                     block_ready_i,
    output logic [BLOCK_BYTES*8-1:0] block_o,
    output logic                     block_first_o,
    output logic                     block_last_o,
    output logic [IDX_W:0]           block_len_o,
    output logic [LL_W-1:0]          t_o,
    output logic                     overrun_o
);

    localparam int BLOCK_W = BLOCK_BYTES * 8;
    localparam int LEN_W   = IDX_W + 1;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [BLOCK_W-1:0] buf_q;
    logic               first_q, last_q;
    logic               first_o_q, last_o_q;
    logic [LEN_W-1:0]   len_q;
    logic [LL_W-1:0]    t_q;
    logic               overrun_q;

    logic               wr_en;
    logic               close_en;
    logic               hs_en;
    logic               drop_en;
    logic               close_byte;
    logic               short_last;
    logic [IDX_W-1:0]   rem;
    logic [LEN_W-1:0]   n_len;
    logic               first_eff;
    logic               last_eff;
    logic [LL_W-1:0]    t_next;

    // Closing-byte detection uses the flags that arrive with this very byte, so a
    // one-byte block (idx 0 closing) still sees the correct first/last values.
    always_comb begin
        rem        = ll_i[IDX_W-1:0];
        short_last = block_last_i && (rem != '0);
        close_byte = (data_idx_i == IDX_W'(BLOCK_BYTES - 1))
                  || (short_last && (data_idx_i == rem - IDX_W'(1)));
        n_len      = short_last ? {1'b0, rem} : LEN_W'(BLOCK_BYTES);
        first_eff  = (data_idx_i == '0) ? block_first_i : first_q;
        last_eff   = (data_idx_i == '0) ? block_last_i  : last_q;
        t_next     = (first_eff ? '0 : t_q) + LL_W'(n_len);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path through the
    // case statement can leave a signal unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        ready_v_o = 1'b0;
        block_v_o = 1'b0;
        wr_en     = 1'b0;
        close_en  = 1'b0;
        hs_en     = 1'b0;
        drop_en   = 1'b0;
        case (state_q)
            FILL: begin
                ready_v_o = 1'b1;
                if (data_v_i) begin
                    wr_en = 1'b1;
                    if (close_byte) begin
                        close_en = 1'b1;
                        state_d  = FULL;
                    end
                end
            end
            FULL: begin
                block_v_o = 1'b1;
                drop_en   = data_v_i;
                if (block_ready_i) begin
                    hs_en   = 1'b1;
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    // NOTE: the block buffer is reset rather than left uninitialised: zero padding of
    // unwritten lanes depends on every lane starting at 0 after reset and handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_q <= '0;
        end else if (hs_en) begin
            buf_q <= '0;
        end else begin
            for (int k = 0; k < BLOCK_BYTES; k++) begin
                if (wr_en && (data_idx_i == IDX_W'(k))) begin
                    buf_q[8*k +: 8] <= data_i;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            first_q <= 1'b0;
            last_q  <= 1'b0;
        end else if (wr_en && (data_idx_i == '0)) begin
            first_q <= block_first_i;
            last_q  <= block_last_i;
        end
    end

    // Presented-block descriptors only move on a closing byte; they hold through FULL
    // and across the handshake until the next block closes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            first_o_q <= 1'b0;
            last_o_q  <= 1'b0;
            len_q     <= '0;
            t_q       <= '0;
        end else if (close_en) begin
            first_o_q <= first_eff;
            last_o_q  <= last_eff;
            len_q     <= n_len;
            t_q       <= t_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overrun_q <= 1'b0;
        end else if (drop_en) begin
            overrun_q <= 1'b1;
        end
    end

    assign block_o       = buf_q;
    assign block_first_o = first_o_q;
    assign block_last_o  = last_o_q;
    assign block_len_o   = len_q;
    assign t_o           = t_q;
    assign overrun_o     = overrun_q;

endmodule

// File: tb/tb_msg_block_assembler.sv
// Scoreboard bench for msg_block_assembler: expected blocks are queued as bytes are
// driven and compared when the assembler presents each block.
module tb_msg_block_assembler;

    logic         clk;
    logic         reset;
    logic         data_v_i;
    logic [7:0]   data_i;
    logic [5:0]   data_idx_i;
    logic         block_first_i;
    logic         block_last_i;
    logic [63:0]  ll_i;
    logic         ready_v_o;
    logic         block_v_o;
    logic         block_ready_i;
    logic [511:0] block_o;
    logic         block_first_o;
    logic         block_last_o;
    logic [6:0]   block_len_o;
    logic [63:0]  t_o;
    logic         overrun_o;

    typedef struct {
        logic [511:0] blk;
        logic         first;
        logic         last;
        logic [6:0]   len;
        logic [63:0]  t;
    } exp_t;

    exp_t         sb[$];
    int           n_vec = 0;
    int           n_err = 0;
    logic [63:0]  t_model;
    logic [511:0] last_blk;
    logic [63:0]  last_t;

    msg_block_assembler dut (
        .clk           (clk),
        .reset         (reset),
        .data_v_i      (data_v_i),
        .data_i        (data_i),
        .data_idx_i    (data_idx_i),
        .block_first_i (block_first_i),
        .block_last_i  (block_last_i),
        .ll_i          (ll_i),
        .ready_v_o     (ready_v_o),
        .block_v_o     (block_v_o),
        .block_ready_i (block_ready_i),
        .block_o       (block_o),
        .block_first_o (block_first_o),
        .block_last_o  (block_last_o),
        .block_len_o   (block_len_o),
        .t_o           (t_o),
        .overrun_o     (overrun_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] pat(input int base, input int step, input int p);
        return 8'(base + step * p);
    endfunction

    task automatic drive_byte(input logic [5:0] idx, input logic [7:0] d,
                              input logic f, input logic l);
        data_v_i      = 1'b1;
        data_idx_i    = idx;
        data_i        = d;
        block_first_i = f;
        block_last_i  = l;
        @(posedge clk); #1;
        data_v_i      = 1'b0;
    endtask

    // Drives block b of a message of length ll and queues what the core should see.
    task automatic fill_block(input int ll, input int base, input int step, input int b);
        exp_t e;
        int   nblk = (ll + 63) / 64;
        int   len;
        e.first = (b == 0);
        e.last  = (b == nblk - 1);
        len     = (e.last && (ll % 64) != 0) ? (ll % 64) : 64;
        e.len   = 7'(len);
        t_model = (e.first ? 64'd0 : t_model) + 64'(len);
        e.t     = t_model;
        e.blk   = '0;
        for (int i = 0; i < len; i++) e.blk[8*i +: 8] = pat(base, step, b * 64 + i);
        sb.push_back(e);
        ll_i = 64'(ll);
        for (int i = 0; i < len; i++)
            drive_byte(6'(i), pat(base, step, b * 64 + i), e.first, e.last);
    endtask

    // Waits (bounded) for the presented block, compares it, optionally stalls the core
    // and injects bytes, then completes the handshake.
    task automatic collect(input int hold, input bit inject, input bit inject_hs);
        exp_t e;
        int   w = 0;
        while (!block_v_o && w < 8) begin
            @(posedge clk); #1;
            w++;
        end
        check("latency", 512'(w), 512'(0));
        check("block_v", 512'(block_v_o), 512'(1));
        check("sb_nonempty", 512'(sb.size() > 0), 512'(1));
        if (sb.size() == 0) return;
        e = sb.pop_front();
        check("block", block_o, e.blk);
        check("first", 512'(block_first_o), 512'(e.first));
        check("last", 512'(block_last_o), 512'(e.last));
        check("len", 512'(block_len_o), 512'(e.len));
        check("t", 512'(t_o), 512'(e.t));
        check("ready_full", 512'(ready_v_o), 512'(0));
        last_blk = block_o;
        last_t   = t_o;
        block_ready_i = 1'b0;
        for (int h = 0; h < hold; h++) begin
            if (inject && h == 3) begin
                data_v_i = 1'b1; data_idx_i = 6'd5; data_i = 8'hEE;
            end
            @(posedge clk); #1;
            data_v_i = 1'b0;
            check("hold_block", block_o, e.blk);
            check("hold_t", 512'(t_o), 512'(e.t));
            check("hold_ready", 512'(ready_v_o), 512'(0));
            check("hold_valid", 512'(block_v_o), 512'(1));
        end
        if (inject) check("overrun_hold", 512'(overrun_o), 512'(1));
        block_ready_i = 1'b1;
        if (inject_hs) begin
            data_v_i = 1'b1; data_idx_i = 6'd0; data_i = 8'h99;
            block_first_i = 1'b1; block_last_i = 1'b1;
        end
        @(posedge clk); #1;
        block_ready_i = 1'b0;
        data_v_i      = 1'b0;
        check("hs_valid", 512'(block_v_o), 512'(0));
        check("hs_ready", 512'(ready_v_o), 512'(1));
        check("hs_cleared", block_o, 512'(0));
        check("hs_t_hold", 512'(t_o), 512'(e.t));
        check("hs_len_hold", 512'(block_len_o), 512'(e.len));
        if (inject_hs) check("overrun_hs", 512'(overrun_o), 512'(1));
    endtask

    task automatic send_msg(input int ll, input int base, input int step);
        int nblk = (ll + 63) / 64;
        for (int b = 0; b < nblk; b++) begin
            fill_block(ll, base, step, b);
            collect(0, 1'b0, 1'b0);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_block"}, block_o, 512'(0));
        check({tag, "_valid"}, 512'(block_v_o), 512'(0));
        check({tag, "_ready"}, 512'(ready_v_o), 512'(1));
        check({tag, "_t"}, 512'(t_o), 512'(0));
        check({tag, "_len"}, 512'(block_len_o), 512'(0));
        check({tag, "_flags"}, 512'({block_first_o, block_last_o}), 512'(0));
        check({tag, "_overrun"}, 512'(overrun_o), 512'(0));
    endtask

    initial begin
        reset = 1'b1; data_v_i = 1'b0; data_i = '0; data_idx_i = '0;
        block_first_i = 1'b0; block_last_i = 1'b0; ll_i = '0; block_ready_i = 1'b0;
        t_model = '0; last_blk = '0; last_t = '0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("rst");
        reset = 1'b0;
        @(posedge clk); #1;

        // Full single block, bytes 00..3F
        send_msg(64, 8'h00, 1);
        check("t1_word0", 512'(last_blk[63:0]), 512'(64'h0706050403020100));
        check("t1_t", 512'(last_t), 512'(64));

        // Short single block AA,BB,CC
        send_msg(3, 8'hAA, 8'h11);
        check("t2_word0", 512'(last_blk[63:0]), 512'(64'h0000000000CCBBAA));
        check("t2_upper", 512'(last_blk[511:64]), 512'(0));

        // Two blocks, 100 bytes
        send_msg(100, 8'h30, 3);
        check("t3_t", 512'(last_t), 512'(100));
        check("t3_pad", 512'(last_blk[511:288]), 512'(0));

        check("ovr_clear", 512'(overrun_o), 512'(0));

        // Core stalls 10 cycles, one byte injected while FULL
        fill_block(64, 8'h7B, 5, 0);
        collect(10, 1'b1, 1'b0);

        // Reset mid-fill, then a short block must show no residue
        ll_i = 64'd64;
        for (int i = 0; i < 20; i++) drive_byte(6'(i), pat(8'h55, 1, i), 1'b1, 1'b1);
        #2 reset = 1'b1;
        #1 check_reset_state("mid_rst");
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        send_msg(10, 8'hA0, 1);

        // Byte arrives in the handshake cycle
        check("ovr_clear2", 512'(overrun_o), 512'(0));
        fill_block(3, 8'h01, 2, 0);
        collect(0, 1'b0, 1'b1);

        // Duplicate index overwrites its lane
        ll_i = 64'd2;
        sb.push_back('{blk: 512'h3322, first: 1'b1, last: 1'b1, len: 7'd2, t: 64'd2});
        drive_byte(6'd0, 8'h11, 1'b1, 1'b1);
        drive_byte(6'd0, 8'h22, 1'b1, 1'b1);
        drive_byte(6'd1, 8'h33, 1'b1, 1'b1);
        collect(0, 1'b0, 1'b0);

        // One-byte message closes on idx 0
        send_msg(1, 8'hC3, 1);
        check("t_one", 512'(last_t), 512'(1));

        check("sb_drained", 512'(sb.size()), 512'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
